// File: rtl/plb_line_fetch.sv
// plb_line_fetch: PLB read master filling the TFT RGB line buffer, one 80-cacheline line per get_line request.
module plb_line_fetch #(
  parameter int C_LINES  = 480,
  parameter int C_BURSTS = 80
) (
  input  logic        plb_clk,
  input  logic        plb_rst_n,
  input  logic        tft_on_reg,
  input  logic [0:10] base_addr,
  input  logic        frame_start,
  input  logic        get_line,
  output logic        M_request,
  output logic [0:31] M_ABus,
  output logic        M_RNW,
  output logic [0:3]  M_size,
  output logic [0:7]  M_BE,
  input  logic        PLB_MAddrAck,
  input  logic        PLB_MRdDAck,
  input  logic [0:63] PLB_MRdDBus,
  input  logic        PLB_MErr,
  output logic [0:63] PLB_BRAM_data,
  output logic        PLB_BRAM_we,
  output logic [0:1]  PLB_BRAM_addr_lsb,
  output logic        PLB_BRAM_addr_en,
  output logic        line_done,
  output logic        busy,
  output logic        overrun,
  output logic        bus_err
);
  typedef enum logic [2:0] {IDLE, REQ, DATA, NEXT, DONE} state_t;
  state_t      state;
  logic [8:0]  line;
  logic [6:0]  burst;
  logic [1:0]  beat;
  logic [8:0]  line_nxt;
  assign M_RNW    = 1'b1;
  assign M_size   = 4'b0010;
  assign M_BE     = 8'hFF;
  assign line_nxt = (line == 9'(C_LINES - 1)) ? 9'd0 : line + 9'd1;
  always_ff @(posedge plb_clk or negedge plb_rst_n) begin
    if (!plb_rst_n) begin
      state             <= IDLE;
      line              <= '0;
      burst             <= '0;
      beat              <= '0;
      M_request         <= 1'b0;
      M_ABus            <= '0;
      PLB_BRAM_data     <= '0;
      PLB_BRAM_we       <= 1'b0;
      PLB_BRAM_addr_lsb <= '0;
      PLB_BRAM_addr_en  <= 1'b0;
      line_done         <= 1'b0;
      busy              <= 1'b0;
      overrun           <= 1'b0;
      bus_err           <= 1'b0;
    end else begin
      PLB_BRAM_we      <= 1'b0;
      PLB_BRAM_addr_en <= 1'b0;
      line_done        <= 1'b0;
      if (PLB_MErr) bus_err <= 1'b1;
      if (get_line && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (get_line && tft_on_reg) begin
          state     <= REQ;
          burst     <= '0;
          beat      <= '0;
          busy      <= 1'b1;
          M_request <= 1'b1;
          M_ABus    <= {base_addr, frame_start ? 9'd0 : line, 7'd0, 5'd0};
        end
        REQ: if (PLB_MAddrAck) begin
          state     <= DATA;
          M_request <= 1'b0;
          beat      <= '0;
        end
        // Beats are written even on PLB_MErr so the buffer's address counter never slips.
        DATA: if (PLB_MRdDAck) begin
          PLB_BRAM_data     <= PLB_MRdDBus;
          PLB_BRAM_we       <= 1'b1;
          PLB_BRAM_addr_lsb <= beat;
          beat              <= beat + 2'd1;
          if (beat == 2'd3) begin
            PLB_BRAM_addr_en <= 1'b1;
            state            <= NEXT;
          end
        end
        NEXT: if (burst == 7'(C_BURSTS - 1)) state <= DONE;
        else begin
          burst     <= burst + 7'd1;
          state     <= REQ;
          M_request <= 1'b1;
          M_ABus    <= {base_addr, line, burst + 7'd1, 5'd0};
        end
        DONE: begin
          line_done <= 1'b1;
          line      <= line_nxt;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (frame_start) line <= '0;
    end
  end
endmodule

// File: tb/tb_plb_line_fetch.sv
// tb_plb_line_fetch: scoreboard bench for plb_line_fetch with a simple PLB slave model.
module tb_plb_line_fetch;
  localparam int LINES = 6;
  localparam int BURSTS = 80;
  logic plb_clk = 0, plb_rst_n = 0, tft_on_reg = 0, frame_start = 0, get_line = 0;
  logic [0:10] base_addr = 11'h001;
  logic M_request, M_RNW;
  logic [0:31] M_ABus;
  logic [0:3] M_size;
  logic [0:7] M_BE;
  logic PLB_MAddrAck = 0, PLB_MRdDAck = 0, PLB_MErr = 0;
  logic [0:63] PLB_MRdDBus = '0;
  logic [0:63] PLB_BRAM_data;
  logic PLB_BRAM_we, PLB_BRAM_addr_en, line_done, busy, overrun, bus_err;
  logic [0:1] PLB_BRAM_addr_lsb;

  plb_line_fetch #(.C_LINES(LINES), .C_BURSTS(BURSTS)) dut (
    .plb_clk(plb_clk), .plb_rst_n(plb_rst_n), .tft_on_reg(tft_on_reg), .base_addr(base_addr),
    .frame_start(frame_start), .get_line(get_line), .M_request(M_request), .M_ABus(M_ABus),
    .M_RNW(M_RNW), .M_size(M_size), .M_BE(M_BE), .PLB_MAddrAck(PLB_MAddrAck),
    .PLB_MRdDAck(PLB_MRdDAck), .PLB_MRdDBus(PLB_MRdDBus), .PLB_MErr(PLB_MErr),
    .PLB_BRAM_data(PLB_BRAM_data), .PLB_BRAM_we(PLB_BRAM_we), .PLB_BRAM_addr_lsb(PLB_BRAM_addr_lsb),
    .PLB_BRAM_addr_en(PLB_BRAM_addr_en), .line_done(line_done), .busy(busy), .overrun(overrun),
    .bus_err(bus_err));

  always #5 plb_clk = ~plb_clk;

  int errors = 0, checks = 0;
  logic [31:0] addr_q[$];
  logic [66:0] wr_q[$];
  int done_pend = 0, wr_cnt = 0, cyc = 0, last_en_cyc = 0, exp_line = 0;
  bit gaps = 0, err_mode = 0, prev_req = 0;
  logic [31:0] sa;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(string name, logic [127:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected none", name, act);
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge plb_clk);
      #1;
    end
  endtask

  // Slave: acks each request, returns 4 beats tagged with the captured address and beat index.
  initial forever begin
    @(posedge plb_clk);
    #1;
    if (M_request && plb_rst_n) begin
      sa = M_ABus;
      PLB_MAddrAck = 1;
      tick();
      PLB_MAddrAck = 0;
      for (int i = 0; i < 4; i++) begin
        if (gaps) tick(int'($urandom_range(0, 2)));
        PLB_MRdDAck = 1;
        PLB_MRdDBus = {sa, 30'b0, 2'(i)};
        PLB_MErr = err_mode && sa[11:5] == 7'd10 && i == 0;
        tick();
        PLB_MRdDAck = 0;
        PLB_MErr = 0;
      end
    end
  end

  initial forever begin
    @(negedge plb_clk);
    cyc++;
    if (plb_rst_n) begin
      if (M_request && !prev_req) begin
        if (addr_q.size() == 0) fail("unexpected_request", M_ABus);
        else chk("req_addr", M_ABus, addr_q.pop_front());
      end
      if (PLB_BRAM_we) begin
        wr_cnt++;
        if (PLB_BRAM_addr_en) last_en_cyc = cyc;
        if (wr_q.size() == 0) fail("unexpected_write", PLB_BRAM_data);
        else chk("write", {PLB_BRAM_data, PLB_BRAM_addr_lsb, PLB_BRAM_addr_en}, wr_q.pop_front());
      end else if (PLB_BRAM_addr_en) fail("addr_en_without_we", 1);
      if (line_done) begin
        if (done_pend == 0) fail("unexpected_line_done", 1);
        else begin
          done_pend--;
          chk("done_latency", cyc - last_en_cyc, 2);
        end
      end
    end
    prev_req = M_request;
  end

  task automatic expect_line(int ln);
    logic [31:0] a;
    for (int b = 0; b < BURSTS; b++) begin
      a = (32'(base_addr) << 21) + (32'(ln) << 12) + (32'(b) << 5);
      addr_q.push_back(a);
      for (int i = 0; i < 4; i++) wr_q.push_back({a, 30'b0, 2'(i), 2'(i), i == 3});
    end
    done_pend++;
  endtask

  task automatic fetch(bit fs_too = 0);
    if (fs_too) exp_line = 0;
    expect_line(exp_line);
    wr_cnt = 0;
    get_line = 1;
    frame_start = fs_too;
    tick();
    get_line = 0;
    frame_start = 0;
    @(negedge plb_clk);
    chk("req_latency", M_request, 1);
    tick();
  endtask

  task automatic wait_done(bit fs_at_done = 0);
    int t = 0;
    while (wr_cnt < 4 * BURSTS && t < 5000) begin
      @(negedge plb_clk);
      #1;
      t++;
    end
    if (t >= 5000) fail("write_timeout", wr_cnt);
    if (fs_at_done) begin
      @(posedge plb_clk);
      #1;
      frame_start = 1;
      tick();
      frame_start = 0;
    end
    t = 0;
    while (busy && t < 100) begin
      tick();
      t++;
    end
    tick(2);
    chk("write_count", wr_cnt, 4 * BURSTS);
    chk("addr_q_empty", addr_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("done_seen", done_pend, 0);
    chk("busy_idle", busy, 0);
    exp_line = fs_at_done ? 0 : (exp_line + 1) % LINES;
  endtask

  task automatic check_reset();
    chk("rst_req", M_request, 0);
    chk("rst_abus", M_ABus, 0);
    chk("rst_we", PLB_BRAM_we, 0);
    chk("rst_addr_en", PLB_BRAM_addr_en, 0);
    chk("rst_lsb", PLB_BRAM_addr_lsb, 0);
    chk("rst_data", PLB_BRAM_data, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("const_rnw", M_RNW, 1);
    chk("const_size", M_size, 4'b0010);
    chk("const_be", M_BE, 8'hFF);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check_reset();
    plb_rst_n = 1;
    tick(2);
    get_line = 1;
    tick();
    get_line = 0;
    tick(5);
    chk("off_busy", busy, 0);
    chk("off_req", M_request, 0);
    chk("off_overrun", overrun, 0);
    tft_on_reg = 1;
    for (int l = 0; l < 3; l++) begin
      fetch();
      wait_done();
    end
    frame_start = 1;
    tick();
    frame_start = 0;
    exp_line = 0;
    fetch();
    wait_done();
    fetch(1);
    wait_done();
    fetch();
    tick(50);
    chk("overrun_clear", overrun, 0);
    tft_on_reg = 0;
    get_line = 1;
    tick();
    get_line = 0;
    wait_done();
    chk("overrun_set", overrun, 1);
    tft_on_reg = 1;
    chk("bus_err_clear", bus_err, 0);
    gaps = 1;
    err_mode = 1;
    fetch();
    wait_done();
    chk("bus_err_set", bus_err, 1);
    err_mode = 0;
    for (int l = 0; l < 4; l++) begin
      fetch();
      wait_done();
    end
    gaps = 0;
    fetch();
    wait_done(1);
    fetch();
    wait_done();
    fetch();
    tick(100);
    plb_rst_n = 0;
    #2;
    check_reset();
    addr_q.delete();
    wr_q.delete();
    done_pend = 0;
    exp_line = 0;
    tick(20);
    plb_rst_n = 1;
    tick(2);
    fetch();
    wait_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
